mastermind_ctrl: RTL and testbench

MASTERMIND_CTRL -- requirements
Module: mastermind_ctrl

---
 rtl/mastermind_if.sv | 31 +++
 rtl/mastermind_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mastermind_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_if.sv
// Handshake and score bus between a game host and the mastermind controller.
interface mastermind_if;
    localparam int unsigned CODE_W  = 12;
    localparam int unsigned COUNT_W = 3;
    localparam int unsigned ROUND_W = 4;

    logic               start;
    logic [CODE_W-1:0]  master;
    logic               master_valid;
    logic [CODE_W-1:0]  guess;
    logic               guess_valid;
    logic               guess_ready;
    logic [COUNT_W-1:0] red;
    logic [COUNT_W-1:0] white;
    logic               score_valid;
    logic [ROUND_W-1:0] round;
    logic               won;
    logic               lost;

    // Host side: drives codes and requests, observes the score.
    modport host (
        output start, master, master_valid, guess, guess_valid,
        input  guess_ready, red, white, score_valid, round, won, lost
    );

    // Controller side.
    modport ctrl (
        input  start, master, master_valid, guess, guess_valid,
        output guess_ready, red, white, score_valid, round, won, lost
    );
endinterface

// File: rtl/mastermind_ctrl.sv
// Mastermind game controller: captures a secret code, then scores guesses
// serially (4 peg cycles for red, 8 color cycles for total) and tracks win/loss.
module mastermind_ctrl #(
    parameter int unsigned MAX_ROUNDS = 8
) (
    input  logic         clock,
    input  logic         reset_L,
    mastermind_if.ctrl   bus
);
    localparam int unsigned PEG_W   = 3;
    localparam int unsigned NPEG    = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned RND_W   = 4;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        WAIT_GUESS  = 3'd2,
        SCORE_RED   = 3'd3,
        SCORE_WHITE = 3'd4,
        REPORT      = 3'd5,
        DONE        = 3'd6
    } state_t;

    state_t                        r_state;
    logic [NPEG-1:0][PEG_W-1:0]    r_master;
    logic [NPEG-1:0][PEG_W-1:0]    r_guess;
    logic [IDX_W-1:0]              r_idx;
    logic [CNT_W-1:0]              r_red_acc;
    logic [CNT_W-1:0]              r_total;
    logic [CNT_W-1:0]              r_red;
    logic [CNT_W-1:0]              r_white;
    logic                          r_score_valid;
    logic [RND_W-1:0]              r_round;
    logic                          r_won;
    logic                          r_lost;
    logic                          r_guess_ready;

    logic [CNT_W-1:0]              w_cnt_m;
    logic [CNT_W-1:0]              w_cnt_g;
    logic [CNT_W-1:0]              w_min;
    logic [CNT_W-1:0]              w_total_next;
    logic [CNT_W-1:0]              w_white;
    logic                          w_peg_hit;
    logic                          w_last_round;

    // Occurrences of color r_idx in each code; min of the two feeds the total.
    always_comb begin
        w_cnt_m = '0;
        w_cnt_g = '0;
        for (int i = 0; i < NPEG; i++) begin
            w_cnt_m = w_cnt_m + CNT_W'(r_master[i] == r_idx);
            w_cnt_g = w_cnt_g + CNT_W'(r_guess[i] == r_idx);
        end
        w_min = (w_cnt_m < w_cnt_g) ? w_cnt_m : w_cnt_g;
    end

    assign w_total_next = r_total + w_min;
    // Total always includes every exact hit, so this difference cannot underflow.
    assign w_white      = w_total_next - r_red_acc;
    assign w_peg_hit    = (r_master[r_idx[1:0]] == r_guess[r_idx[1:0]]);
    assign w_last_round = (r_round == RND_W'(MAX_ROUNDS));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= IDLE;
            r_master      <= '0;
            r_guess       <= '0;
            r_idx         <= '0;
            r_red_acc     <= '0;
            r_total       <= '0;
            r_red         <= '0;
            r_white       <= '0;
            r_score_valid <= 1'b0;
            r_round       <= '0;
            r_won         <= 1'b0;
            r_lost        <= 1'b0;
            r_guess_ready <= 1'b0;
        end else begin
            r_score_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= LOAD;
                        r_round <= '0;
                        r_red   <= '0;
                        r_white <= '0;
                        r_won   <= 1'b0;
                        r_lost  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.master_valid) begin
                        r_master      <= bus.master;
                        r_state       <= WAIT_GUESS;
                        r_guess_ready <= 1'b1;
                    end
                end
                WAIT_GUESS: begin
                    if (bus.guess_valid && r_guess_ready) begin
                        r_guess       <= bus.guess;
                        r_guess_ready <= 1'b0;
                        r_red_acc     <= '0;
                        r_total       <= '0;
                        r_idx         <= '0;
                        r_state       <= SCORE_RED;
                    end
                end
                SCORE_RED: begin
                    if (w_peg_hit) begin
                        r_red_acc <= r_red_acc + CNT_W'(1);
                    end
                    if (r_idx == IDX_W'(NPEG - 1)) begin
                        r_idx   <= '0;
                        r_state <= SCORE_WHITE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                SCORE_WHITE: begin
                    r_total <= w_total_next;
                    r_idx   <= r_idx + IDX_W'(1);
                    // Final color: publish the score so it is valid during REPORT.
                    if (r_idx == IDX_W'(7)) begin
                        r_red         <= r_red_acc;
                        r_white       <= w_white;
                        r_score_valid <= 1'b1;
                        if (!w_last_round) begin
                            r_round <= r_round + RND_W'(1);
                        end
                        r_state <= REPORT;
                    end
                end
                REPORT: begin
                    if (r_red_acc == CNT_W'(NPEG)) begin
                        r_won   <= 1'b1;
                        r_state <= DONE;
                    end else if (w_last_round) begin
                        r_lost  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_guess_ready <= 1'b1;
                        r_state       <= WAIT_GUESS;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.guess_ready = r_guess_ready;
    assign bus.red         = r_red;
    assign bus.white       = r_white;
    assign bus.score_valid = r_score_valid;
    assign bus.round       = r_round;
    assign bus.won         = r_won;
    assign bus.lost        = r_lost;

endmodule

// File: tb/tb_mastermind_ctrl.sv
// Randomized bench for mastermind_ctrl, scored against a code-level reference model.
module tb_mastermind_ctrl;
    localparam int MAXR = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [11:0] m_master;
    int          m_round;
    bit          m_won;
    bit          m_lost;

    mastermind_if bus ();

    mastermind_ctrl #(.MAX_ROUNDS(MAXR)) dut (
        .clock   (clk),
        .reset_L (rst_n),
        .bus     (bus.ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference scoring straight from the game rules.
    task automatic ref_score(input logic [11:0] m, input logic [11:0] g,
                             output int red, output int white);
        int cm[8];
        int cg[8];
        int total;
        red = 0;
        total = 0;
        for (int c = 0; c < 8; c++) begin
            cm[c] = 0;
            cg[c] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            int pm;
            int pg;
            pm = int'(m[3*i +: 3]);
            pg = int'(g[3*i +: 3]);
            if (pm == pg) red++;
            cm[pm]++;
            cg[pg]++;
        end
        for (int c = 0; c < 8; c++) total += (cm[c] < cg[c]) ? cm[c] : cg[c];
        white = total - red;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_red"},         bus.red, 0);
        check_eq({tag, "_white"},       bus.white, 0);
        check_eq({tag, "_score_valid"}, bus.score_valid, 0);
        check_eq({tag, "_round"},       bus.round, 0);
        check_eq({tag, "_won"},         bus.won, 0);
        check_eq({tag, "_lost"},        bus.lost, 0);
        check_eq({tag, "_guess_ready"}, bus.guess_ready, 0);
    endtask

    task automatic start_game(input logic [11:0] m);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("start_round", bus.round, 0);
        check_eq("start_won",   bus.won, 0);
        check_eq("start_lost",  bus.lost, 0);
        check_eq("start_red",   bus.red, 0);
        check_eq("start_white", bus.white, 0);
        @(negedge clk);
        bus.master       = m;
        bus.master_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.master_valid = 1'b0;
        bus.master       = ~m;
        check_eq("load_ready", bus.guess_ready, 1);
        m_master = m;
        m_round  = 0;
        m_won    = 1'b0;
        m_lost   = 1'b0;
    endtask

    // One scored guess; with noise, guess_valid stays high and start pulses mid-score.
    task automatic play_guess(input logic [11:0] g, input bit noise);
        int er;
        int ew;
        int pulses;
        int lat_ok;
        ref_score(m_master, g, er, ew);
        @(negedge clk);
        check_eq("pre_ready", bus.guess_ready, 1);
        bus.guess       = g;
        bus.guess_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!noise) bus.guess_valid = 1'b0;
        pulses = 0;
        lat_ok = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (noise && k == 3) bus.start = 1'b1;
            if (noise && k == 4) bus.start = 1'b0;
            if (bus.score_valid === 1'b1) begin
                pulses++;
                if (k == 12) lat_ok = 1;
            end
        end
        bus.guess_valid = 1'b0;
        check_eq("sv_pulses",  pulses, 1);
        check_eq("sv_latency", lat_ok, 1);
        if (m_round < MAXR) m_round++;
        check_eq("red",   bus.red, er);
        check_eq("white", bus.white, ew);
        check_eq("round", bus.round, m_round);
        if (er == 4) m_won = 1'b1;
        else if (m_round == MAXR) m_lost = 1'b1;
        @(posedge clk);
        #1;
        check_eq("sv_clear",   bus.score_valid, 0);
        check_eq("won",        bus.won, m_won);
        check_eq("lost",       bus.lost, m_lost);
        check_eq("post_ready", bus.guess_ready, (m_won || m_lost) ? 0 : 1);
        check_eq("red_hold",   bus.red, er);
    endtask

    function automatic logic [11:0] rand_code();
        return 12'($urandom);
    endfunction

    initial begin
        int pulses;
        logic [11:0] g;
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.master       = '0;
        bus.master_valid = 1'b0;
        bus.guess        = '0;
        bus.guess_valid  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.guess_valid  = 1'b1;
        bus.master_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.guess_valid  = 1'b0;
        bus.master_valid = 1'b0;
        check_outputs_zero("idle_hold");

        // Directed games on master {1,2,3,4}.
        start_game(12'o4321);
        play_guess(12'o1234, 1'b0);
        play_guess(12'o2211, 1'b0);
        play_guess(12'o5555, 1'b0);
        play_guess(12'o4321, 1'b0);
        check_eq("win_round", bus.round, 4);

        // Guesses in DONE are dropped.
        @(negedge clk);
        bus.guess_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (bus.score_valid === 1'b1) pulses++;
        end
        bus.guess_valid = 1'b0;
        check_eq("done_no_score", pulses, 0);
        check_eq("done_round",    bus.round, 4);
        check_eq("done_won",      bus.won, 1);

        // Losing game with a noisy first guess, then ignored guesses in DONE.
        start_game(rand_code());
        for (int r = 0; r < MAXR; r++) begin
            do g = rand_code(); while (g == m_master);
            play_guess(g, r == 0);
        end
        check_eq("lost_round", bus.round, MAXR);
        check_eq("lost_flag",  bus.lost, 1);
        check_eq("lost_nowon", bus.won, 0);
        @(negedge clk);
        bus.guess_valid = 1'b1;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (bus.score_valid === 1'b1) pulses++;
        end
        bus.guess_valid = 1'b0;
        check_eq("lost_no_score", pulses, 0);
        check_eq("lost_sat",      bus.round, MAXR);

        // Random games until win or loss; some guesses equal the secret.
        for (int gm = 0; gm < 6; gm++) begin
            start_game(rand_code());
            while (!m_won && !m_lost) begin
                g = ($urandom_range(0, 5) == 0) ? m_master : rand_code();
                play_guess(g, $urandom_range(0, 3) == 0);
            end
        end

        // Asynchronous reset while scoring colors.
        start_game(12'o4321);
        play_guess(12'o4301, 1'b0);
        @(negedge clk);
        bus.guess       = 12'o1234;
        bus.guess_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.guess_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.score_valid === 1'b1) pulses++;
        end
        check_eq("rst_no_score", pulses, 0);
        check_outputs_zero("rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
